// File: rtl/instruction_fetch_pkg.sv
// Shared widths, opcode encoding and instruction field positions for the fetch path.
package instruction_fetch_pkg;

  localparam int unsigned IF_ADDR_WIDTH  = 16;
  localparam int unsigned IF_INSTR_WIDTH = 28;
  localparam int unsigned OPCODE_W       = 4;

  typedef enum logic [OPCODE_W-1:0] {
    OP_NOP = 4'h0,
    OP_ADD = 4'h1,
    OP_SUB = 4'h2,
    OP_AND = 4'h3,
    OP_OR  = 4'h4,
    OP_LDI = 4'h5,
    OP_JMP = 4'hF
  } opcode_e;

  // Field bit positions: {op, dst, src1, src0} or {op, dst, lit16}
  localparam int unsigned OP_MSB   = 27;
  localparam int unsigned OP_LSB   = 24;
  localparam int unsigned DST_MSB  = 23;
  localparam int unsigned DST_LSB  = 16;
  localparam int unsigned SRC1_MSB = 15;
  localparam int unsigned SRC1_LSB = 8;
  localparam int unsigned SRC0_MSB = 7;
  localparam int unsigned SRC0_LSB = 0;
  localparam int unsigned LIT_MSB  = 15;
  localparam int unsigned LIT_LSB  = 0;

endpackage

// File: rtl/instruction_fetch_fifo.sv
// Small power-of-two FIFO of {pc, word} entries with a flush that empties it in one cycle.
module fetch_fifo #(
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned DATA_W = 44,
  parameter logic [DATA_W-1:0] RESET_DATA = '0,
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [DATA_W-1:0] wdata,
  output logic [CNT_W-1:0]  count,
  output logic              head_valid,
  output logic [DATA_W-1:0] head_data
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              pop_ok;
  logic              push_ok;

  // Pointers wrap naturally because DEPTH is a power of two
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    pop_ok   = pop && (count_q != '0);
    push_ok  = push && ((count_q < CNT_W'(DEPTH)) || pop_ok);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) begin
        mem_d[wr_ptr_q] = wdata;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop_ok) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= RESET_DATA;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= mem_d[i];
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign count      = count_q;
  assign head_valid = (count_q != '0);
  assign head_data  = mem_q[rd_ptr_q];

endmodule

// File: rtl/instruction_fetch.sv
// Fetch master: steps the PC through the combinational ROM, buffers {pc, word} and
// hands entries to decode; an execute-stage redirect flushes the buffer and reloads the PC.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = IF_ADDR_WIDTH,
  parameter int unsigned INSTR_WIDTH = IF_INSTR_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0,
  parameter int unsigned DEPTH = 2,
  localparam int unsigned LVL_W = $clog2(DEPTH + 1)
) (
  input  logic                   Clock,
  input  logic                   Reset,
  output logic [ADDR_WIDTH-1:0]  oAddress,
  input  logic [INSTR_WIDTH-1:0] iInstruction,
  input  logic                   iRedirect,
  input  logic [ADDR_WIDTH-1:0]  iRedirectAddress,
  output logic                   oInstrValid,
  input  logic                   iInstrReady,
  output logic [INSTR_WIDTH-1:0] oInstruction,
  output logic [ADDR_WIDTH-1:0]  oInstrPC,
  output logic [LVL_W-1:0]       oLevel
);

  localparam int unsigned ENTRY_W = ADDR_WIDTH + INSTR_WIDTH;
  localparam logic [INSTR_WIDTH-1:0] NOP_WORD =
    {OP_NOP, (INSTR_WIDTH - OPCODE_W)'(0)};
  localparam logic [ENTRY_W-1:0] RESET_ENTRY = {ADDR_WIDTH'(0), NOP_WORD};

  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic                  push;
  logic                  pop;
  logic                  head_valid;
  logic [ENTRY_W-1:0]    head_data;
  logic [LVL_W-1:0]      fifo_count;

  // Redirect wins: the word at the old PC is dropped and the target is fetched next cycle
  always_comb begin
    pop  = head_valid && iInstrReady;
    push = !iRedirect && ((fifo_count < LVL_W'(DEPTH)) || pop);
    pc_d = pc_q;
    if (iRedirect) begin
      pc_d = iRedirectAddress;
    end else if (push) begin
      pc_d = pc_q + ADDR_WIDTH'(1);
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  fetch_fifo #(
    .DEPTH      (DEPTH),
    .DATA_W     (ENTRY_W),
    .RESET_DATA (RESET_ENTRY)
  ) u_fifo (
    .clk        (Clock),
    .rst_n      (Reset),
    .push       (push),
    .pop        (pop),
    .flush      (iRedirect),
    .wdata      ({pc_q, iInstruction}),
    .count      (fifo_count),
    .head_valid (head_valid),
    .head_data  (head_data)
  );

  assign oAddress     = pc_q;
  assign oInstrValid  = head_valid;
  assign oInstrPC     = head_data[ENTRY_W-1:INSTR_WIDTH];
  assign oInstruction = head_data[INSTR_WIDTH-1:0];
  assign oLevel       = fifo_count;

endmodule
